// File: rtl/mmu_result_collector.sv
// Deskews MMU result columns into whole rows and queues them for the accumulator writer.
// Optional MMU_COLLECTOR_STATS_EN adds a saturating dropped_rows_o counter.
`timescale 1ns/1ps
module mmu_result_collector #(
    parameter int MATRIX_WIDTH = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [ADDR_WIDTH-1:0]                row_count_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_i,
    input  logic [MATRIX_WIDTH-1:0][31:0]        result_in_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [MATRIX_WIDTH-1:0][31:0]        out_data_o,
    output logic [ADDR_WIDTH-1:0]                out_row_addr_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overflow_o
`ifdef MMU_COLLECTOR_STATS_EN
    ,
    output logic [15:0]                          dropped_rows_o
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int KW = ADDR_WIDTH + $clog2(MATRIX_WIDTH) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    typedef logic [MATRIX_WIDTH-1:0][31:0] row_t;

    row_t                  row_w;
    logic [1:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d, last_k_q, last_k_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d, ovf_q, ovf_d;
    row_t                  mem_dat_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push_w, pop_w, full_w, wr_w, drop_w, start_acc_w;

    // Column j is delayed MATRIX_WIDTH-1-j edges so all lanes of a row line up with the last column.
    genvar j;
    for (j = 0; j < MATRIX_WIDTH - 1; j++) begin : g_dly
        localparam int N = MATRIX_WIDTH - 1 - j;
        logic [31:0] dly_q [N];
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < N; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= result_in_i[j];
                for (int i = 1; i < N; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign row_w[j] = dly_q[N-1];
    end
    assign row_w[MATRIX_WIDTH-1] = result_in_i[MATRIX_WIDTH-1];

    assign start_acc_w = (state_q == S_IDLE) && start_i && (row_count_i != '0);
    assign push_w      = (state_q == S_COLLECT) && (k_q >= KW'(MATRIX_WIDTH - 1));
    assign pop_w       = (cnt_q != '0) && out_ready_i;
    assign full_w      = (cnt_q == CW'(FIFO_DEPTH));
    assign wr_w        = push_w && (!full_w || pop_w);
    assign drop_w      = push_w && full_w && !pop_w;
    assign cnt_d       = cnt_q + CW'(wr_w) - CW'(pop_w);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        last_k_d = last_k_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q | drop_w;
        case (state_q)
            S_IDLE: begin
                if (start_i && row_count_i == '0) begin
                    done_d = 1'b1;
                end else if (start_acc_w) begin
                    state_d  = S_COLLECT;
                    k_d      = KW'(1);
                    last_k_d = KW'(row_count_i) + KW'(MATRIX_WIDTH - 2);
                    addr_d   = base_addr_i;
                    ovf_d    = 1'b0;
                end
            end
            S_COLLECT: begin
                k_d = k_q + KW'(1);
                // Dropped rows still consume an address so later rows keep theirs.
                if (push_w) addr_d = addr_q + ADDR_WIDTH'(1);
                if (k_q == last_k_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            last_k_q <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat_q[i]  <= '0;
                mem_addr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            last_k_q <= last_k_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            if (wr_w) begin
                mem_dat_q[wr_ptr_q]  <= row_w;
                mem_addr_q[wr_ptr_q] <= addr_q;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop_w) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign out_valid_o    = (cnt_q != '0);
    assign out_data_o     = mem_dat_q[rd_ptr_q];
    assign out_row_addr_o = mem_addr_q[rd_ptr_q];
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign overflow_o     = ovf_q;

`ifdef MMU_COLLECTOR_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (start_acc_w)                             drop_cnt_d = '0;
        else if (drop_w && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end
    assign dropped_rows_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_mmu_result_collector.sv
// Scoreboard bench: queue-of-rows reference model fed from the same inputs as the collector.
`timescale 1ns/1ps
module tb_mmu_result_collector;
    localparam int MW    = 4;
    localparam int DEPTH = 2;
    localparam int AW    = 8;

    typedef logic [MW-1:0][31:0] row_t;
    typedef struct packed { row_t dat; logic [AW-1:0] addr; } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, out_valid, out_ready, busy, done, overflow;
    logic [AW-1:0] row_count, base_addr, out_row_addr;
    row_t          result_in, out_data;
`ifdef MMU_COLLECTOR_STATS_EN
    logic [15:0]   dropped_rows;
`endif

    always #5 clk = ~clk;

    mmu_result_collector #(.MATRIX_WIDTH(MW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .row_count_i(row_count),
        .base_addr_i(base_addr), .result_in_i(result_in), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_row_addr_o(out_row_addr),
        .busy_o(busy), .done_o(done), .overflow_o(overflow)
`ifdef MMU_COLLECTOR_STATS_EN
        , .dropped_rows_o(dropped_rows)
`endif
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    row_t A [64];

    task automatic check(input string name, input logic [MW*32-1:0] act, input logic [MW*32-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a bounded queue of rows; row r is complete t=r+MW-1 edges after start.
    bit            m_active, m_busy, m_done, m_ovf, m_pop, m_nd;
    int            m_t, m_n, m_cnt, m_cnt_pre, m_drop, m_r;
    logic [AW-1:0] m_base;
    row_t          M [64];
    exp_t          m_e;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            m_cnt_pre = m_cnt;
            m_pop     = (m_cnt > 0) && out_ready;
            m_nd      = 0;
            if (m_pop) m_cnt--;
            if (!m_active && start) begin
                if (row_count == 0) m_nd = 1;
                else begin
                    m_active = 1; m_t = 0; m_n = int'(row_count); m_base = base_addr;
                    m_ovf = 0; m_drop = 0;
                end
            end
            if (m_active) begin
                for (int j = 0; j < MW; j++) begin
                    m_r = m_t - j;
                    if (m_r >= 0 && m_r < m_n) M[m_r][j] = result_in[j];
                end
                m_r = m_t - (MW - 1);
                if (m_r >= 0 && m_r < m_n) begin
                    if (m_cnt_pre == DEPTH && !m_pop) begin
                        m_ovf = 1;
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        m_cnt++;
                        m_e.dat  = M[m_r];
                        m_e.addr = AW'(int'(m_base) + m_r);
                        exp_q.push_back(m_e);
                    end
                end
                if (m_t >= m_n + MW - 2 && m_cnt == 0) begin
                    m_active = 0;
                    m_nd     = 1;
                end
                m_t++;
            end
            m_done = m_nd;
            m_busy = m_active;
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", out_valid, m_cnt > 0);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("overflow", overflow, m_ovf);
`ifdef MMU_COLLECTOR_STATS_EN
            check("dropped_rows", dropped_rows, m_drop);
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_row: got addr %0d expected no row", out_row_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("row_data", out_data, mon_e.dat);
                    check("row_addr", out_row_addr, mon_e.addr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input int c0, input int c1, input int c2, input int c3);
        A[r][0] = c0; A[r][1] = c1; A[r][2] = c2; A[r][3] = c3;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 stalled until well after collection
    task automatic run_batch(input int n, input logic [AW-1:0] base, input int ready_mode,
                             input int extra_start_k, input int rst_k);
        int r;
        for (int k = 0; ; k++) begin
            start     = (k == 0) || (k == extra_start_k);
            row_count = (k == 0) ? AW'(n) : AW'(4);
            base_addr = base;
            for (int j = 0; j < MW; j++) begin
                r = k - j;
                result_in[j] = (r >= 0 && r < n) ? A[r][j] : $urandom();
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (k > n + MW + 3);
            endcase
            if (ready_mode == 2 && k == n + MW + 2) begin
                check("ovf_sticky", overflow, 1'b1);
`ifdef MMU_COLLECTOR_STATS_EN
                check("dropped_two", dropped_rows, 16'd2);
`endif
            end
            rst = (k == rst_k);
            cyc();
            if (k == rst_k) break;
            if (k >= n + MW && !m_active && m_cnt == 0) break;
            if (k >= 300) begin
                n_cmp++; n_bad++;
                $display("FAIL batch_timeout: got still busy expected idle within 300 cycles");
                break;
            end
        end
        start = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_count = '0; base_addr = '0; out_ready = 1'b1; result_in = '0;
        cyc();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_addr", out_row_addr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        set_row(0, 30565, 59635, 40982, 7353);
        set_row(1, 10939, 18295, 21906, 1807);
        set_row(2, 78999, 52173, 26952, 5055);
        set_row(3, 38752, 27456, 27784, 2206);
        run_batch(4, 8'd0, 0, -1, -1);

        set_row(0, -17778, 21992, 16310, 2786);
        set_row(1, -6627, 6398, 3934, 888);
        set_row(2, -23146, 27305, 16840, 4565);
        set_row(3, -15966, 18802, 12796, 1822);
        run_batch(4, 8'd254, 0, -1, -1);

        run_batch(4, 8'd10, 2, -1, -1);
        run_batch(4, 8'd20, 0, 2, -1);
        run_batch(0, 8'd30, 0, -1, -1);
        run_batch(4, 8'd40, 0, -1, 2);
        run_batch(4, 8'd50, 0, -1, -1);

        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < 12; r++)
                for (int j = 0; j < MW; j++) A[r][j] = $urandom();
            run_batch($urandom_range(1, 12), AW'($urandom()), 1, -1, -1);
        end

        repeat (4) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400us");
        $fatal(1, "timeout");
    end
endmodule
